// File: rtl/adc_scan_sequencer_if.sv
// Handshake bundle between the scan sequencer, the host register block and
// the shared SPI ADC wrapper. The master side is the environment (host plus
// ADC wrapper); the slave side is the sequencer itself.
interface adc_scan_sequencer_if;
    logic        host_req;
    logic [2:0]  host_ch;
    logic        host_ack;
    logic [9:0]  host_data;
    logic [23:0] adc_in_data;
    logic        adc_in_wr;
    logic [23:0] adc_out_data;
    logic        adc_out_wr;

    modport master (
        output host_req, host_ch, adc_out_data, adc_out_wr,
        input  host_ack, host_data, adc_in_data, adc_in_wr
    );

    modport slave (
        input  host_req, host_ch, adc_out_data, adc_out_wr,
        output host_ack, host_data, adc_in_data, adc_in_wr
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Sequencer for a shared 8-channel SPI ADC: periodic round-robin scanning of
// enabled channels plus one-shot host conversions, one conversion in flight
// at a time, with the latest 10-bit result per channel kept in a small
// register file.
module adc_scan_sequencer #(
    parameter int unsigned SCAN_PERIOD = 1000,
    parameter int unsigned TIMEOUT     = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en_i,
    input  logic [7:0] ch_mask_i,
    input  logic [2:0] rd_ch_i,
    output logic [9:0] rd_data_o,
    output logic [7:0] valid_mask_o,
    output logic       round_done_o,
    output logic       timeout_err_o,
    adc_scan_sequencer_if.slave bus
);

    localparam logic [23:0] PERIOD_LAST = 24'(SCAN_PERIOD - 1);
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;

    state_t      state_q, state_d;
    logic [23:0] period_q, period_d;
    logic        pending_q, pending_d;
    logic        active_q, active_d;
    logic [7:0]  remain_q, remain_d;
    logic [2:0]  ch_q, ch_d;
    logic        owner_host_q, owner_host_d;
    logic [9:0]  result_q, result_d;
    logic [15:0] to_q, to_d;
    logic [9:0]  host_data_q, host_data_d;
    logic        round_done_q, round_done_d;
    logic        timeout_err_q, timeout_err_d;
    logic [7:0]  valid_q, valid_d;
    logic [9:0]  regs_q [8];
    logic [9:0]  rd_data_q;
    logic [2:0]  next_ch;
    logic        unused_adc_bits;

    assign unused_adc_bits = ^bus.adc_out_data[23:10];

    // Lowest-numbered channel still waiting in the current round.
    always_comb begin
        next_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (remain_q[i]) next_ch = 3'(i);
        end
    end

    // Conversion FSM, period counter and round bookkeeping next-state logic.
    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        pending_d     = pending_q;
        active_d      = active_q;
        remain_d      = remain_q;
        ch_d          = ch_q;
        owner_host_d  = owner_host_q;
        result_d      = result_q;
        to_d          = to_q;
        host_data_d   = host_data_q;
        round_done_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        valid_d       = valid_q;

        unique case (state_q)
            IDLE: begin
                to_d = 16'd0;
                if (bus.host_req) begin
                    ch_d         = bus.host_ch;
                    owner_host_d = 1'b1;
                    state_d      = ISSUE;
                end else if (scan_en_i && active_q && (remain_q != 8'd0)) begin
                    ch_d         = next_ch;
                    owner_host_d = 1'b0;
                    remain_d     = remain_q & ~(8'b1 << next_ch);
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                to_d    = to_q + 16'd1;
                state_d = WAIT;
            end
            WAIT: begin
                to_d = to_q + 16'd1;
                if (bus.adc_out_wr) begin
                    result_d = bus.adc_out_data[9:0];
                    if (owner_host_q) begin
                        host_data_d = bus.adc_out_data[9:0];
                    end else if (active_q && (remain_q == 8'd0)) begin
                        round_done_d = 1'b1;
                        active_d     = 1'b0;
                    end
                    state_d = STORE;
                end else if (to_q >= TO_LAST) begin
                    timeout_err_d = 1'b1;
                    if (!owner_host_q && active_q && (remain_q == 8'd0)) begin
                        round_done_d = 1'b1;
                        active_d     = 1'b0;
                    end
                    state_d = IDLE;
                end
            end
            STORE: begin
                valid_d = valid_q | (8'b1 << ch_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!scan_en_i) begin
            period_d  = 24'd0;
            pending_d = 1'b0;
            active_d  = 1'b0;
            remain_d  = 8'd0;
        end else begin
            if (pending_q && !active_q) begin
                pending_d = 1'b0;
                if (ch_mask_i == 8'd0) begin
                    round_done_d = 1'b1;
                end else begin
                    active_d = 1'b1;
                    remain_d = ch_mask_i;
                end
            end
            if (period_q >= PERIOD_LAST) begin
                period_d  = 24'd0;
                pending_d = 1'b1;
            end else begin
                period_d = period_q + 24'd1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            period_q      <= 24'd0;
            pending_q     <= 1'b0;
            active_q      <= 1'b0;
            remain_q      <= 8'd0;
            ch_q          <= 3'd0;
            owner_host_q  <= 1'b0;
            result_q      <= 10'd0;
            to_q          <= 16'd0;
            host_data_q   <= 10'd0;
            round_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            valid_q       <= 8'd0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            pending_q     <= pending_d;
            active_q      <= active_d;
            remain_q      <= remain_d;
            ch_q          <= ch_d;
            owner_host_q  <= owner_host_d;
            result_q      <= result_d;
            to_q          <= to_d;
            host_data_q   <= host_data_d;
            round_done_q  <= round_done_d;
            timeout_err_q <= timeout_err_d;
            valid_q       <= valid_d;
        end
    end

    // Result register file, written at the end of STORE; the read port
    // samples before the write lands, so a same-cycle read sees old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= 10'd0;
            rd_data_q <= 10'd0;
        end else begin
            if (state_q == STORE) regs_q[ch_q] <= result_q;
            rd_data_q <= regs_q[rd_ch_i];
        end
    end

    assign bus.adc_in_wr   = (state_q == ISSUE);
    assign bus.adc_in_data = {21'd0, ch_q};
    assign bus.host_ack    = (state_q == STORE) && owner_host_q;
    assign bus.host_data   = host_data_q;
    assign rd_data_o       = rd_data_q;
    assign valid_mask_o    = valid_q;
    assign round_done_o    = round_done_q;
    assign timeout_err_o   = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer: directed corner sequences, a
// register-file read table, and a randomized host/scan phase checked
// against a per-channel result memory kept by the ADC wrapper model.
module tb_adc_scan_sequencer;

    localparam int unsigned ScanPeriod = 100;
    localparam int unsigned Timeout    = 512;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       scanEn = 1'b0;
    logic [7:0] chMask = 8'd0;
    logic [2:0] rdCh = 3'd0;
    logic [9:0] rdData;
    logic [7:0] validMask;
    logic       roundDone;
    logic       timeoutErr;

    adc_scan_sequencer_if busIf();

    adc_scan_sequencer #(.SCAN_PERIOD(ScanPeriod), .TIMEOUT(Timeout)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_en_i    (scanEn),
        .ch_mask_i    (chMask),
        .rd_ch_i      (rdCh),
        .rd_data_o    (rdData),
        .valid_mask_o (validMask),
        .round_done_o (roundDone),
        .timeout_err_o(timeoutErr),
        .bus          (busIf)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ch;
        logic [9:0] expData;
        logic       expValid;
    } readVec_t;

    readVec_t    readTable [8];
    int          passChecks = 0;
    int          totalChecks = 0;
    int          cyc = 0;
    int          ackCnt = 0;
    int          ackCyc = 0;
    int          respCyc = 0;
    int          errCyc = -1;
    logic [2:0]  lastRespCh = 3'd0;
    logic [23:0] issueQ [$];
    int          issueCycQ [$];
    int          doneCycQ [$];
    int          adcLat = 40;
    bit          adcRespond = 1'b1;
    bit          adcRandData = 1'b0;
    bit          spuriousReq = 1'b0;
    logic [9:0]  refMem [8];
    logic [7:0]  refValid = 8'd0;
    bit          ok;

    // Event monitor, sampling one time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (busIf.adc_in_wr === 1'b1) begin
                issueQ.push_back(busIf.adc_in_data);
                issueCycQ.push_back(cyc);
            end
            if (roundDone === 1'b1) doneCycQ.push_back(cyc);
            if (busIf.host_ack === 1'b1) begin
                ackCnt++;
                ackCyc = cyc;
            end
            if (timeoutErr === 1'b1 && errCyc < 0) errCyc = cyc;
        end
    end

    // ADC wrapper model: answers each start strobe after adcLat cycles and
    // remembers the latest value it produced for every channel.
    initial begin
        logic [2:0] reqCh;
        logic [9:0] val;
        busIf.adc_out_wr   = 1'b0;
        busIf.adc_out_data = 24'd0;
        forever begin
            @(negedge clk);
            if (spuriousReq) begin
                spuriousReq        = 1'b0;
                busIf.adc_out_data = 24'h3FF;
                busIf.adc_out_wr   = 1'b1;
                @(negedge clk);
                busIf.adc_out_wr   = 1'b0;
            end else if (busIf.adc_in_wr === 1'b1) begin
                reqCh = busIf.adc_in_data[2:0];
                repeat (adcLat) @(negedge clk);
                if (adcRespond) begin
                    val = adcRandData ? 10'($urandom_range(0, 1023)) : (10'h100 + 10'(reqCh));
                    busIf.adc_out_data = {14'd0, val};
                    busIf.adc_out_wr   = 1'b1;
                    respCyc            = cyc;
                    lastRespCh         = reqCh;
                    refMem[reqCh]      = val;
                    refValid[reqCh]    = 1'b1;
                    @(negedge clk);
                    busIf.adc_out_wr   = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act === exp) passChecks++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic reportTimeout(input string name);
        totalChecks++;
        $display("[TB] FAIL %s: wait budget expired, got no event, expected one", name);
    endtask

    task automatic resetDut();
        scanEn         = 1'b0;
        chMask         = 8'd0;
        rdCh           = 3'd0;
        busIf.host_req = 1'b0;
        busIf.host_ch  = 3'd0;
        rst_n          = 1'b0;
        for (int i = 0; i < 8; i++) refMem[i] = 10'd0;
        refValid = 8'd0;
        repeat (3) @(negedge clk);
        issueQ.delete();
        issueCycQ.delete();
        doneCycQ.delete();
        ackCnt = 0;
        errCyc = -1;
        rst_n  = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitIssues(input int n, input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            if (issueQ.size() >= n) return;
            @(negedge clk);
        end
        reportTimeout(name);
    endtask

    task automatic waitDone(input int n, input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            if (doneCycQ.size() >= n) return;
            @(negedge clk);
        end
        reportTimeout(name);
    endtask

    task automatic waitAck(input int budget, input string name, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busIf.host_ack === 1'b1) begin
                found = 1'b1;
                return;
            end
        end
        reportTimeout(name);
    endtask

    task automatic applyStimulus(input logic [2:0] ch);
        rdCh = ch;
        @(negedge clk);
    endtask

    // Main test sequence.
    initial begin
        readTable[0] = '{3'd0, 10'h100, 1'b1};
        readTable[1] = '{3'd1, 10'h000, 1'b0};
        readTable[2] = '{3'd2, 10'h102, 1'b1};
        readTable[3] = '{3'd3, 10'h000, 1'b0};
        readTable[4] = '{3'd4, 10'h000, 1'b0};
        readTable[5] = '{3'd5, 10'h105, 1'b1};
        readTable[6] = '{3'd6, 10'h000, 1'b0};
        readTable[7] = '{3'd7, 10'h000, 1'b0};

        busIf.host_req = 1'b0;
        busIf.host_ch  = 3'd0;
        #2;

        // Reset state
        resetDut();
        checkOutput("reset host_ack", 32'(busIf.host_ack), 32'd0);
        checkOutput("reset host_data", 32'(busIf.host_data), 32'd0);
        checkOutput("reset adc_in_wr", 32'(busIf.adc_in_wr), 32'd0);
        checkOutput("reset adc_in_data", 32'(busIf.adc_in_data), 32'd0);
        checkOutput("reset rd_data", 32'(rdData), 32'd0);
        checkOutput("reset valid_mask", 32'(validMask), 32'd0);
        checkOutput("reset round_done", 32'(roundDone), 32'd0);
        checkOutput("reset timeout_err", 32'(timeoutErr), 32'd0);

        // Scan of channels 0 and 2, then a host request during a scan WAIT
        adcLat = 40; adcRespond = 1'b1; adcRandData = 1'b0;
        chMask = 8'h05;
        scanEn = 1'b1;
        waitIssues(2, 400, "first round issues");
        checkOutput("round1 first adc_in_data", 32'(issueQ[0]), 32'd0);
        checkOutput("round1 second adc_in_data", 32'(issueQ[1]), 32'd2);
        waitDone(2, 400, "two round_done pulses");
        checkOutput("round_done spacing", 32'(doneCycQ[1] - doneCycQ[0]), 32'(ScanPeriod));
        waitIssues(5, 200, "round3 first issue");
        checkOutput("round3 first adc_in_data", 32'(issueQ[4]), 32'd0);
        repeat (5) @(negedge clk);
        busIf.host_ch  = 3'd5;
        busIf.host_req = 1'b1;
        waitAck(200, "host ch5 ack", ok);
        busIf.host_req = 1'b0;
        if (ok) begin
            checkOutput("host ch5 host_data", 32'(busIf.host_data), 32'h105);
            checkOutput("host_ack latency", 32'(ackCyc - respCyc), 32'd1);
        end
        waitIssues(7, 200, "scan resumes after host");
        checkOutput("host issued after scan ch0", 32'(issueQ[5]), 32'd5);
        checkOutput("scan ch2 after host", 32'(issueQ[6]), 32'd2);
        scanEn = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("valid_mask after scan+host", 32'(validMask), 32'h25);
        checkOutput("no timeout in normal run", 32'(timeoutErr), 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(readTable[i].ch);
            checkOutput($sformatf("rd_data ch%0d", i), 32'(rdData), 32'(readTable[i].expData));
            checkOutput($sformatf("valid_mask bit %0d", i), 32'(validMask[readTable[i].ch]), 32'(readTable[i].expValid));
        end

        // ADC never answers: timeout after TIMEOUT cycles, next channel follows
        resetDut();
        adcRespond = 1'b0;
        chMask = 8'h03;
        scanEn = 1'b1;
        waitIssues(1, 300, "timeout first issue");
        for (int k = 0; k < 700 && errCyc < 0; k++) @(negedge clk);
        if (errCyc < 0) reportTimeout("timeout_err rise");
        else checkOutput("timeout_err delay", 32'(errCyc - issueCycQ[0]), 32'(Timeout));
        waitIssues(2, 20, "issue after timeout");
        checkOutput("channel after timeout", 32'(issueQ[1]), 32'd1);
        repeat (100) @(negedge clk);
        checkOutput("timeout_err sticky", 32'(timeoutErr), 32'd1);
        scanEn = 1'b0;

        // Reset while a host conversion is in WAIT
        resetDut();
        adcRespond = 1'b1; adcLat = 40;
        busIf.host_ch  = 3'd3;
        busIf.host_req = 1'b1;
        waitIssues(1, 20, "host ch3 issue");
        repeat (5) @(negedge clk);
        busIf.host_req = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("reset mid-WAIT host_ack count", 32'(ackCnt), 32'd0);
        checkOutput("reset mid-WAIT valid_mask", 32'(validMask), 32'd0);
        checkOutput("reset mid-WAIT issue count", 32'(issueQ.size()), 32'd1);
        applyStimulus(3'd3);
        checkOutput("reset mid-WAIT rd ch3", 32'(rdData), 32'd0);

        // Empty channel mask: rounds complete with no conversions
        resetDut();
        chMask = 8'h00;
        scanEn = 1'b1;
        repeat (350) @(negedge clk);
        checkOutput("empty mask adc_in_wr count", 32'(issueQ.size()), 32'd0);
        checkOutput("empty mask round_done count", 32'(doneCycQ.size()), 32'd3);
        if (doneCycQ.size() >= 2)
            checkOutput("empty mask round_done spacing", 32'(doneCycQ[1] - doneCycQ[0]), 32'(ScanPeriod));
        scanEn = 1'b0;

        // Spurious result strobe in IDLE, then read-during-write on ch2
        spuriousReq = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("spurious host_ack count", 32'(ackCnt), 32'd0);
        checkOutput("spurious valid_mask", 32'(validMask), 32'd0);
        checkOutput("spurious adc_in_wr count", 32'(issueQ.size()), 32'd0);
        rdCh = 3'd2;
        adcLat = 10;
        busIf.host_ch  = 3'd2;
        busIf.host_req = 1'b1;
        waitAck(50, "host ch2 ack", ok);
        busIf.host_req = 1'b0;
        if (ok) begin
            checkOutput("host ch2 host_data", 32'(busIf.host_data), 32'h102);
            @(negedge clk);
            checkOutput("rd_data during STORE old", 32'(rdData), 32'd0);
            @(negedge clk);
            checkOutput("rd_data after STORE new", 32'(rdData), 32'h102);
            checkOutput("valid_mask after ch2", 32'(validMask), 32'h04);
        end

        // Randomized scan traffic with interleaved host requests
        resetDut();
        adcRandData = 1'b1;
        chMask = 8'($urandom);
        scanEn = 1'b1;
        for (int t = 0; t < 20; t++) begin
            logic [2:0] hostCh;
            chMask = 8'($urandom);
            adcLat = $urandom_range(2, 30);
            repeat ($urandom_range(0, 60)) @(negedge clk);
            hostCh = 3'($urandom_range(0, 7));
            busIf.host_ch  = hostCh;
            busIf.host_req = 1'b1;
            waitAck(400, $sformatf("random host ack %0d", t), ok);
            busIf.host_req = 1'b0;
            if (ok) begin
                checkOutput($sformatf("random host_data %0d", t), 32'(busIf.host_data), 32'(refMem[hostCh]));
                checkOutput($sformatf("random host channel %0d", t), 32'(lastRespCh), 32'(hostCh));
            end
        end
        scanEn = 1'b0;
        repeat (80) @(negedge clk);
        checkOutput("random valid_mask", 32'(validMask), 32'(refValid));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i));
            checkOutput($sformatf("random rd_data ch%0d", i), 32'(rdData), 32'(refMem[i]));
        end
        checkOutput("random no timeout", 32'(timeoutErr), 32'd0);

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Sequences the shared 8-channel SPI ADC wrapper: periodic round-robin scan of enabled channels, plus on-demand host conversions, one conversion outstanding at a time.
- Stores the latest 10-bit result per channel in a register file for the host/bus side.
- Sits between the bus register block and the ADC wrapper: drives its in_data/in_wr and consumes its out_data/out_wr.

Parameters:
- SCAN_PERIOD, 1000: clk cycles between scan-round starts; 24-bit counter, must be >= 1.
- TIMEOUT, 512: max clk cycles in WAIT for adc_out_wr before aborting; 16-bit counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- scan_en  in  1  enables periodic scanning
- ch_mask  in  8  channels included in a scan round (bit n = channel n)
- host_req  in  1  request a one-shot conversion; held until host_ack
- host_ch  in  3  channel for host_req, sampled when the request is accepted
- host_ack  out  1  one-cycle pulse when the host result is valid
- host_data  out  10  host conversion result, held until the next host_ack
- adc_in_data  out  24  to ADC wrapper, {21'b0, channel}
- adc_in_wr  out  1  one-cycle conversion start strobe
- adc_out_data  in  24  from ADC wrapper; result in bits [9:0]
- adc_out_wr  in  1  one-cycle result-ready strobe
- rd_ch  in  3  register-file read address
- rd_data  out  10  result for rd_ch, registered with 1-cycle read latency
- valid_mask  out  8  bit n set once channel n has a stored result
- round_done  out  1  one-cycle pulse when a scan round completes
- timeout_err  out  1  sticky; set on any WAIT timeout

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; all outputs 0; register file 0; valid_mask=0; period counter=0.
  - Reset mid-conversion: the wrapper result that follows is ignored, because FSM is IDLE.
- Period counter:
  - Free-runs while scan_en=1; held at 0 while scan_en=0.
  - On reaching SCAN_PERIOD-1: wraps to 0 and sets round_pending.
  - If a round is still active when the wrap occurs, round_pending stays set (rounds are never skipped, never queued beyond one).
- Round start:
  - Consumes round_pending; latches ch_mask into round_mask.
  - round_mask=0: round_done pulses next cycle, no conversion issued.
  - Channels are visited in ascending order 0..7, skipping cleared bits.
- FSM states:
  - IDLE:
    - host_req=1 -> latch host_ch, owner=HOST, go ISSUE.
    - Else, if a round is active with channels remaining (or round_pending) -> owner=SCAN, next channel, go ISSUE.
    - Host always has priority, but only at IDLE; an in-flight scan conversion is never preempted.
  - ISSUE (1 cycle): adc_in_wr=1, adc_in_data={21'b0,ch}; timeout counter cleared; go WAIT.
  - WAIT:
    - adc_out_wr=1 -> capture adc_out_data[9:0], go STORE.
    - Timeout counter reaches TIMEOUT-1 -> timeout_err<=1, result discarded, go IDLE.
      - A SCAN conversion counts as visited.
      - A HOST request stays pending and is retried.
  - STORE (1 cycle):
    - Write result to reg[ch]; set valid_mask[ch].
    - Owner=HOST: host_ack=1, host_data=result.
    - Owner=SCAN: the last channel of the round also pulses round_done in this cycle.
    - Go IDLE.
- adc_out_wr outside WAIT: ignored.
- Latency:
  - IDLE->adc_in_wr: 1 cycle.
  - adc_out_wr->host_ack and register write: 1 cycle.
  - Host requests therefore see at most one scan conversion ahead of them.
- Read port: rd_data <= reg[rd_ch] every clk. Same-cycle STORE to the same address returns the old value; the new value appears on the following cycle.
- scan_en dropped mid-round: the current conversion completes, no further channels are issued, round_pending is cleared, and round_done is not pulsed.
- host_req deasserted before acceptance: no conversion. After acceptance, the request runs to completion regardless.

Test Plan:
- Reset release, SCAN_PERIOD=100, ch_mask=8'h05, ADC model returns 10'h100+ch after 40 cycles -> adc_in_data = 0 then 2; reg0=0x100, reg2=0x102; valid_mask=8'h05; one round_done pulse per 100 cycles.
- host_req with host_ch=5 while scan ch0 is in WAIT -> ch0 completes first, then adc_in_data=5; host_ack 1 cycle after adc_out_wr; host_data=0x105.
- ADC model never responds, TIMEOUT=512 -> timeout_err=1 exactly 512 cycles after adc_in_wr; next channel is issued; timeout_err stays 1.
- rst_n pulsed low while in WAIT, ADC result arrives afterwards -> no register write, valid_mask=0, host_ack=0.
- ch_mask=8'h00, scan_en=1 -> zero adc_in_wr pulses; round_done pulses once per period.
- Spurious adc_out_wr in IDLE, and rd_ch=2 read during a STORE to ch2 -> state unchanged; rd_data returns the old value, then the new value one cycle later.
